// File: rtl/l4_route_seq.sv
// Route-job sequencer for the 32x32 L4 array: clear, mark source/target, then
// alternate expand/trace commands with a fixed status wait, reporting found/iterations.
module l4_route_seq #(
  parameter int unsigned NRBITS     = 5,
  parameter int unsigned NCBITS     = 5,
  parameter int unsigned NROWS      = 32,
  parameter int unsigned NCOLS      = 32,
  parameter int unsigned ITBITS     = 8,
  parameter int unsigned MAX_ITER   = 200,
  parameter int unsigned STAT_LAT   = 2,
  parameter logic [2:0]  RS_SINGLE  = 3'd1,
  parameter logic [2:0]  RS_ALL     = 3'd0,
  parameter logic [1:0]  CMD_NOP    = 2'd0,
  parameter logic [1:0]  CMD_WRITE  = 2'd1,
  parameter logic [1:0]  CMD_EXPAND = 2'd2,
  parameter logic [1:0]  CMD_TRACE  = 2'd3,
  parameter logic [3:0]  ST_EMPTY   = 4'd0,
  parameter logic [3:0]  ST_SRC     = 4'd1,
  parameter logic [3:0]  ST_TGT     = 4'd2,
  parameter logic [3:0]  SO_TGT_HIT = 4'hE,
  parameter logic [3:0]  SO_SRC_HIT = 4'hD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              idle,
  input  logic [NRBITS-1:0] src_row,
  input  logic [NCBITS-1:0] src_col,
  input  logic [NRBITS-1:0] tgt_row,
  input  logic [NCBITS-1:0] tgt_col,
  output logic [2:0]        row_range_sel,
  output logic [NRBITS-1:0] row_l_v,
  output logic [NRBITS-1:0] row_u_v,
  output logic [2:0]        col_range_sel,
  output logic [NCBITS-1:0] col_l_v,
  output logic [NCBITS-1:0] col_u_v,
  output logic [1:0]        cell_cmd,
  output logic [3:0]        status_in,
  output logic              ret2ue,
  output logic              extend,
  input  logic [3:0]        array_status,
  output logic              done,
  output logic              found,
  output logic [ITBITS-1:0] iter_count
);

  localparam int unsigned       WW      = $clog2(STAT_LAT + 1);
  localparam logic [WW-1:0]     W_LAST  = WW'(STAT_LAT - 1);
  localparam logic [WW-1:0]     W_ONE   = WW'(1);
  localparam logic [ITBITS-1:0] IT_MAX  = ITBITS'(MAX_ITER);
  localparam logic [ITBITS-1:0] IT_ONE  = ITBITS'(1);
  localparam logic [NRBITS-1:0] ROW_MAX = NRBITS'(NROWS - 1);
  localparam logic [NCBITS-1:0] COL_MAX = NCBITS'(NCOLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_MSRC, S_MTGT, S_EXP, S_EWAIT, S_TRC, S_TWAIT, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [ITBITS-1:0] iter_q, iter_d;
  logic [ITBITS-1:0] trc_q, trc_d;
  logic              found_q, found_d;
  logic [NRBITS-1:0] srow_q, srow_d, trow_q, trow_d;
  logic [NCBITS-1:0] scol_q, scol_d, tcol_q, tcol_d;

  logic              idle_q, idle_d;
  logic              done_q, done_d;
  logic [2:0]        rrs_q, rrs_d, crs_q, crs_d;
  logic [NRBITS-1:0] rl_q, rl_d, ru_q, ru_d;
  logic [NCBITS-1:0] cl_q, cl_d, cu_q, cu_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [3:0]        st_q, st_d;
  logic              ret_q, ret_d;
  logic              ext_q, ext_d;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      iter_q  <= '0;
      trc_q   <= '0;
      found_q <= 1'b0;
      srow_q  <= '0;
      scol_q  <= '0;
      trow_q  <= '0;
      tcol_q  <= '0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      rrs_q   <= RS_ALL;
      crs_q   <= RS_ALL;
      rl_q    <= '0;
      ru_q    <= '0;
      cl_q    <= '0;
      cu_q    <= '0;
      cmd_q   <= CMD_NOP;
      st_q    <= ST_EMPTY;
      ret_q   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      iter_q  <= iter_d;
      trc_q   <= trc_d;
      found_q <= found_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
      trow_q  <= trow_d;
      tcol_q  <= tcol_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      rrs_q   <= rrs_d;
      crs_q   <= crs_d;
      rl_q    <= rl_d;
      ru_q    <= ru_d;
      cl_q    <= cl_d;
      cu_q    <= cu_d;
      cmd_q   <= cmd_d;
      st_q    <= st_d;
      ret_q   <= ret_d;
      ext_q   <= ext_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    iter_d  = iter_q;
    trc_d   = trc_q;
    found_d = found_q;
    srow_d  = srow_q;
    scol_d  = scol_q;
    trow_d  = trow_q;
    tcol_d  = tcol_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          srow_d  = src_row;
          scol_d  = src_col;
          trow_d  = tgt_row;
          tcol_d  = tgt_col;
          iter_d  = '0;
          trc_d   = '0;
          found_d = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_MSRC;
      S_MSRC:  state_d = S_MTGT;
      S_MTGT:  state_d = S_EXP;
      S_EXP: begin
        if (iter_q != IT_MAX) iter_d = iter_q + IT_ONE;
        wait_d  = '0;
        state_d = S_EWAIT;
      end
      S_EWAIT: begin
        if (wait_q == W_LAST) begin
          if (array_status == SO_TGT_HIT) begin
            state_d = S_TRC;
          end else if (iter_q == IT_MAX) begin
            found_d = 1'b0;
            state_d = S_FIN;
          end else begin
            state_d = S_EXP;
          end
        end else begin
          wait_d = wait_q + W_ONE;
        end
      end
      S_TRC: begin
        if (trc_q != IT_MAX) trc_d = trc_q + IT_ONE;
        wait_d  = '0;
        state_d = S_TWAIT;
      end
      S_TWAIT: begin
        if (wait_q == W_LAST) begin
          if (array_status == SO_SRC_HIT) begin
            found_d = 1'b1;
            state_d = S_FIN;
          end else if (trc_q == IT_MAX) begin
            found_d = 1'b0;
            state_d = S_FIN;
          end else begin
            state_d = S_TRC;
          end
        end else begin
          wait_d = wait_q + W_ONE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Array-facing outputs are registered from the current state, so each command
  // reaches the array one cycle after its state; addresses hold outside command states.
  always_comb begin
    idle_d = (state_d == S_IDLE);
    done_d = 1'b0;
    rrs_d  = rrs_q;
    crs_d  = crs_q;
    rl_d   = rl_q;
    ru_d   = ru_q;
    cl_d   = cl_q;
    cu_d   = cu_q;
    st_d   = st_q;
    cmd_d  = CMD_NOP;
    ret_d  = 1'b0;
    ext_d  = 1'b0;
    unique case (state_q)
      S_CLEAR, S_EXP, S_TRC: begin
        rrs_d = RS_ALL;
        crs_d = RS_ALL;
        rl_d  = '0;
        ru_d  = ROW_MAX;
        cl_d  = '0;
        cu_d  = COL_MAX;
        if (state_q == S_CLEAR) begin
          cmd_d = CMD_WRITE;
          st_d  = ST_EMPTY;
        end else if (state_q == S_EXP) begin
          cmd_d = CMD_EXPAND;
          ext_d = 1'b1;
        end else begin
          cmd_d = CMD_TRACE;
          ret_d = 1'b1;
        end
      end
      S_MSRC: begin
        rrs_d = RS_SINGLE;
        crs_d = RS_SINGLE;
        rl_d  = srow_q;
        ru_d  = srow_q;
        cl_d  = scol_q;
        cu_d  = scol_q;
        cmd_d = CMD_WRITE;
        st_d  = ST_SRC;
      end
      S_MTGT: begin
        rrs_d = RS_SINGLE;
        crs_d = RS_SINGLE;
        rl_d  = trow_q;
        ru_d  = trow_q;
        cl_d  = tcol_q;
        cu_d  = tcol_q;
        cmd_d = CMD_WRITE;
        st_d  = ST_TGT;
      end
      S_FIN: begin
        done_d = 1'b1;
        rrs_d  = RS_ALL;
        crs_d  = RS_ALL;
      end
      default: ;
    endcase
  end

  assign idle          = idle_q;
  assign done          = done_q;
  assign found         = found_q;
  assign iter_count    = iter_q;
  assign row_range_sel = rrs_q;
  assign row_l_v       = rl_q;
  assign row_u_v       = ru_q;
  assign col_range_sel = crs_q;
  assign col_l_v       = cl_q;
  assign col_u_v       = cu_q;
  assign cell_cmd      = cmd_q;
  assign status_in     = st_q;
  assign ret2ue        = ret_q;
  assign extend        = ext_q;

endmodule

// File: tb/tb_l4_route_seq.sv
// Bench for l4_route_seq: job table with a scoreboard queue, a behavioural array
// status model keyed on observed EXPAND/TRACE counts, plus reset/busy corner sequences.
module tb_l4_route_seq;

  localparam int unsigned MAXI = 10;
  localparam int unsigned LAT  = 2;

  logic       clk = 1'b0;
  logic       resetn, start, idle, done, found, ret2ue, extend;
  logic [4:0] src_row, src_col, tgt_row, tgt_col;
  logic [2:0] row_range_sel, col_range_sel;
  logic [4:0] row_l_v, row_u_v, col_l_v, col_u_v;
  logic [1:0] cell_cmd;
  logic [3:0] status_in, array_status;
  logic [7:0] iter_count;

  always #5 clk = ~clk;

  l4_route_seq #(
    .NRBITS(5), .NCBITS(5), .NROWS(32), .NCOLS(32), .ITBITS(8),
    .MAX_ITER(MAXI), .STAT_LAT(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .idle(idle),
    .src_row(src_row), .src_col(src_col), .tgt_row(tgt_row), .tgt_col(tgt_col),
    .row_range_sel(row_range_sel), .row_l_v(row_l_v), .row_u_v(row_u_v),
    .col_range_sel(col_range_sel), .col_l_v(col_l_v), .col_u_v(col_u_v),
    .cell_cmd(cell_cmd), .status_in(status_in), .ret2ue(ret2ue), .extend(extend),
    .array_status(array_status), .done(done), .found(found), .iter_count(iter_count)
  );

  typedef struct {
    logic [4:0] sr, sc, tr, tc;
    int         exp_hit, trc_hit;   // 0 = the array never reports that hit
    bit         poke, b2b;
    int         e_iter;
    bit         e_found;
    int         e_nexp, e_ntrc, e_cyc;
  } job_t;

  job_t jobs[8];
  job_t sb[$];
  job_t cur, popped;
  int   errors = 0, checks = 0;
  int   nexp, ntrc, nwr, cyc, ndone;

  function automatic job_t mk(input int sr, input int sc, input int tr, input int tc,
                              input int eh, input int th, input bit pk, input bit bb,
                              input int ei, input bit ef, input int en, input int et,
                              input int ec);
    job_t j;
    j.sr = 5'(sr); j.sc = 5'(sc); j.tr = 5'(tr); j.tc = 5'(tc);
    j.exp_hit = eh; j.trc_hit = th; j.poke = pk; j.b2b = bb;
    j.e_iter = ei; j.e_found = ef; j.e_nexp = en; j.e_ntrc = et; j.e_cyc = ec;
    return j;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: observe outputs at negedge, check commands, advance the array model.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    if (cell_cmd == 2'd1) begin
      case (nwr)
        0: e = 64'({3'd0, 5'd0, 5'd31, 3'd0, 5'd0, 5'd31, 4'd0});
        1: e = 64'({3'd1, cur.sr, cur.sr, 3'd1, cur.sc, cur.sc, 4'd1});
        2: e = 64'({3'd1, cur.tr, cur.tr, 3'd1, cur.tc, cur.tc, 4'd2});
        default: e = '1;
      endcase
      chk($sformatf("write%0d", nwr), 64'({row_range_sel, row_l_v, row_u_v,
          col_range_sel, col_l_v, col_u_v, status_in}), e);
      nwr++;
    end else if (cell_cmd == 2'd2) begin
      nexp++;
      chk("expand_ctl", 64'({extend, ret2ue, row_range_sel, col_range_sel}), 64'(8'b10_000_000));
      if (cur.poke && nexp == 1) begin
        start = 1'b1;
        src_row = 5'd17; src_col = 5'd18; tgt_row = 5'd19; tgt_col = 5'd20;
      end
    end else if (cell_cmd == 2'd3) begin
      ntrc++;
      chk("trace_ctl", 64'({extend, ret2ue, row_range_sel, col_range_sel}), 64'(8'b01_000_000));
    end
    if (ntrc > 0)
      array_status = (cur.trc_hit != 0 && ntrc >= cur.trc_hit) ? 4'hD : 4'h0;
    else
      array_status = (cur.exp_hit != 0 && nexp >= cur.exp_hit) ? 4'hE : 4'h0;
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(done), 64'(0));
      end else begin
        popped = sb.pop_front();
        chk("iter_count", 64'(iter_count), 64'(popped.e_iter));
        chk("found",      64'(found),      64'(popped.e_found));
        chk("cycles",     64'(cyc),        64'(popped.e_cyc));
        chk("n_expand",   64'(nexp),       64'(popped.e_nexp));
        chk("n_trace",    64'(ntrc),       64'(popped.e_ntrc));
        chk("n_write",    64'(nwr),        64'(3));
      end
    end
  endtask

  task automatic start_job(input job_t j);
    src_row = j.sr; src_col = j.sc; tgt_row = j.tr; tgt_col = j.tc;
    start = 1'b1;
    cur = j;
    sb.push_back(j);
    nexp = 0; ntrc = 0; nwr = 0; cyc = -1;
    array_status = 4'h0;
  endtask

  task automatic run_job(input job_t j);
    bit got;
    got = 1'b0;
    start_job(j);
    for (int t = 0; t < 300 && !got; t++) begin
      tick();
      if (done) got = 1'b1;
    end
    chk("job_done_seen", 64'(got), 64'(1));
    if (!j.b2b) begin
      for (int k = 0; k < 2; k++) begin
        tick();
        chk("post_done_idle", 64'({idle, done, cell_cmd}), 64'(4'b1000));
      end
    end
  endtask

  initial begin
    //            sr  sc  tr  tc  eh  th  pk b2b  iter f  nexp ntrc cyc
    jobs[0] = mk( 3,  4,  3,  9,  5,  5, 0, 0,    5, 1,   5,   5, 34);
    jobs[1] = mk( 1,  2, 20, 30,  0,  0, 0, 0,   10, 0,  10,   0, 34);
    jobs[2] = mk( 6,  6, 12,  1,  2,  0, 0, 0,    2, 0,   2,  10, 40);
    jobs[3] = mk( 7,  7,  7,  7,  1,  1, 0, 0,    1, 1,   1,   1, 10);
    jobs[4] = mk( 9,  0,  0,  9, 10,  3, 0, 0,   10, 1,  10,   3, 43);
    jobs[5] = mk( 2,  5,  8, 11,  3,  2, 1, 0,    3, 1,   3,   2, 19);
    jobs[6] = mk( 0,  0, 31, 31,  3,  2, 0, 1,    3, 1,   3,   2, 19);
    jobs[7] = mk(31,  0,  0, 31,  1, 10, 0, 0,    1, 1,   1,  10, 37);

    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1; start = 1'b0; array_status = 4'h0;
    src_row = '0; src_col = '0; tgt_row = '0; tgt_col = '0;
    nexp = 0; ntrc = 0; nwr = 0; cyc = 0; ndone = 0;
    tick();
    tick();
    chk("reset_state", 64'({idle, done, found, iter_count, cell_cmd, status_in, ret2ue, extend,
        row_range_sel, row_l_v, row_u_v, col_range_sel, col_l_v, col_u_v}),
        64'({3'b100, 8'd0, 2'd0, 4'd0, 2'b00, 3'd0, 5'd0, 5'd0, 3'd0, 5'd0, 5'd0}));
    resetn = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_job(jobs[i]);
    chk("done_total", 64'(ndone), 64'(8));

    // Reset during the expansion loop: immediate abort, no completion pulse.
    start_job(mk(4, 4, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int t = 0; t < 50 && nexp < 2; t++) tick();
    chk("reached_expand", 64'(nexp), 64'(2));
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("midjob_reset", 64'({idle, done, found, iter_count, cell_cmd, extend}),
          64'({3'b100, 8'd0, 2'd0, 1'b0}));
    end
    resetn = 1'b0;
    sb.delete();
    ndone = 0;
    for (int k = 0; k < 50; k++) tick();
    chk("no_done_after_reset", 64'({ndone[7:0], idle}), 64'({8'd0, 1'b1}));

    run_job(mk(10, 20, 30, 5, 4, 1, 0, 0, 4, 1, 4, 1, 19));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
